mc_sequencer: RTL
=================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the retire counter (used only under REQ-031).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  level enable; 1 = keep fetching, 0 = stop at next instruction boundary.
REQ-005 opcode  input  3  instruction opcode from IR: 000 add, 001 sli, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ack  input  1  memory completion, one-cycle pulse; may coincide with the first cycle of mem_req.
REQ-008 mem_req  output  1  memory access request, held until mem_ack.
REQ-009 mem_we  output  1  1 = write access (sw only).
REQ-010 iord  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-011 ir_write, pc_write, reg_write  output  1 each  write strobes.
REQ-012 pc_src  output  2  00 = PC+1, 01 = branch target, 10 = jump target.
REQ-013 reg_dst, mem_to_reg, alu_op  output  2 each  same encodings as the single-cycle control decoder.
REQ-014 alu_src_b  output  2  00 = register, 01 = immediate, 10 = branch offset.
REQ-015 state  output  3  current state code; busy  output  1  = (state != IDLE).

Function
REQ-016 States and codes: IDLE 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101; codes 110/111 are unreachable and decode to IDLE on the next edge.
REQ-017 Outputs are combinational from state, the latched opcode, zero and mem_ack; every output not named for a state is 0.
REQ-018 IDLE: run=1 -> FETCH; otherwise stay.
REQ-019 FETCH: mem_req=1, iord=0; while mem_ack=0 stay; on mem_ack: ir_write=1, pc_write=1, pc_src=00, then -> DECODE.
REQ-020 DECODE: latch opcode into an internal register; all later states use the latched copy; alu_src_b=10.
REQ-021 DECODE, j: pc_write=1, pc_src=10, then -> RET.
REQ-022 DECODE, jal: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10, then -> RET.
REQ-023 DECODE, other opcodes: -> EXEC.
REQ-024 EXEC: alu_op per opcode (add 00, sli 10, beq 01, lw/sw/addi 11); alu_src_b=00 for add/beq, 01 otherwise.
REQ-025 EXEC, beq: pc_write=zero, pc_src=01, then -> RET; lw/sw -> MEM; add/sli/addi -> WB.
REQ-026 MEM: mem_req=1, iord=1, mem_we=1 for sw; stay until mem_ack; on ack lw -> WB, sw -> RET.
REQ-027 WB: reg_write=1; reg_dst=01 for add, else 00; mem_to_reg=01 for lw, else 00; then -> RET.
REQ-028 RET: next state is FETCH if run=1 in that cycle, else IDLE; run=0 never aborts an instruction in progress.
REQ-029 mem_ack in IDLE, DECODE, EXEC or WB is ignored.
REQ-030 Zero-wait latencies, FETCH to next FETCH: j/jal 2, beq 3, add/sli/addi/sw 4, lw 5 cycles; each mem_ack wait cycle adds 1.

Configuration
REQ-031 With MC_SEQ_RETIRE_CNT_EN defined: output retire_cnt [CNT_W-1:0], reset 0, +1 on each RET transition, wraps all-ones -> 0; without it: the port and the counter are absent and behaviour is otherwise identical.

Reset
REQ-032 rst=1 forces state IDLE and the latched opcode to 000 immediately, without waiting for clk; all outputs read 0 while reset is held, including mem_req in flight.
REQ-033 After rst falls, the first FETCH occurs on the first edge with run=1.

Verification
REQ-034 rst pulse mid-MEM with mem_req=1 -> mem_req=0 in the same cycle, state=000, busy=0.
REQ-035 run=1, opcode=000, mem_ack tied 1 -> states 001,010,011,101,001; reg_write=1 and reg_dst=01 only in WB.
REQ-036 opcode=100, mem_ack withheld 3 cycles in MEM -> mem_req=1, iord=1, mem_we=0 for 4 cycles; WB has mem_to_reg=01; total 8 cycles.
REQ-037 opcode=110: zero=1 -> pc_write=1, pc_src=01 in EXEC; zero=0 -> pc_write=0; both return to FETCH.
REQ-038 opcode=011 -> DECODE asserts pc_write, reg_write, pc_src=10, reg_dst=10, mem_to_reg=10; run dropped during DECODE -> next state IDLE.
REQ-039 With MC_SEQ_RETIRE_CNT_EN and CNT_W=4: 17 back-to-back j instructions -> retire_cnt = 1.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control sequencer for a small load/store core.
// Walks IDLE -> FETCH -> DECODE -> EXEC -> MEM -> WB. The opcode is latched
// in DECODE, and every later state decodes from that latched copy.
// Returning from an instruction ("retire") goes to FETCH when run=1 and to
// IDLE otherwise. An in-flight instruction always completes before the
// sequencer stops.
// Optional feature: define MC_SEQ_RETIRE_CNT_EN to add the retire_cnt
// output. It is a CNT_W-bit wrapping count of retired instructions.
module mc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [2:0]       opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       state,
`ifdef MC_SEQ_RETIRE_CNT_EN
    output logic [CNT_W-1:0] retire_cnt,
`endif
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLI  = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    state_t     state_r;
    state_t     next_state_s;
    state_t     ret_next_s;
    logic [2:0] op_r;
    logic       retire_s;

    // State register. Reset acts at once and does not wait for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Opcode latch. It captures the IR opcode while in DECODE and holds it otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r <= 3'b000;
        end else if (state_r == S_DECODE) begin
            op_r <= opcode;
        end else begin
            op_r <= op_r;
        end
    end

    // Destination when an instruction retires. run is sampled in the retiring cycle.
    always_comb begin
        ret_next_s = S_IDLE;
        if (run) begin
            ret_next_s = S_FETCH;
        end else begin
            ret_next_s = S_IDLE;
        end
    end

    // Next-state and control-output decode. Every output defaults to 0.
    always_comb begin
        next_state_s = state_r;
        retire_s     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        pc_src       = 2'b00;
        reg_dst      = 2'b00;
        mem_to_reg   = 2'b00;
        alu_op       = 2'b00;
        alu_src_b    = 2'b00;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                iord    = 1'b0;
                if (mem_ack) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    pc_src       = 2'b00;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // The opcode is not latched yet, so decode from the live IR field.
                alu_src_b = 2'b10;
                case (opcode)
                    OP_J: begin
                        pc_write     = 1'b1;
                        pc_src       = 2'b10;
                        retire_s     = 1'b1;
                        next_state_s = ret_next_s;
                    end
                    OP_JAL: begin
                        pc_write     = 1'b1;
                        pc_src       = 2'b10;
                        reg_write    = 1'b1;
                        reg_dst      = 2'b10;
                        mem_to_reg   = 2'b10;
                        retire_s     = 1'b1;
                        next_state_s = ret_next_s;
                    end
                    default: begin
                        next_state_s = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                case (op_r)
                    OP_ADD: begin
                        alu_op       = 2'b00;
                        alu_src_b    = 2'b00;
                        next_state_s = S_WB;
                    end
                    OP_SLI: begin
                        alu_op       = 2'b10;
                        alu_src_b    = 2'b01;
                        next_state_s = S_WB;
                    end
                    OP_BEQ: begin
                        alu_op       = 2'b01;
                        alu_src_b    = 2'b00;
                        pc_write     = zero;
                        pc_src       = 2'b01;
                        retire_s     = 1'b1;
                        next_state_s = ret_next_s;
                    end
                    OP_LW, OP_SW: begin
                        alu_op       = 2'b11;
                        alu_src_b    = 2'b01;
                        next_state_s = S_MEM;
                    end
                    default: begin
                        // addi. j/jal never reach EXEC.
                        alu_op       = 2'b11;
                        alu_src_b    = 2'b01;
                        next_state_s = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (op_r == OP_SW) begin
                    mem_we = 1'b1;
                end else begin
                    mem_we = 1'b0;
                end
                if (mem_ack) begin
                    if (op_r == OP_SW) begin
                        retire_s     = 1'b1;
                        next_state_s = ret_next_s;
                    end else begin
                        next_state_s = S_WB;
                    end
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                if (op_r == OP_ADD) begin
                    reg_dst = 2'b01;
                end else begin
                    reg_dst = 2'b00;
                end
                if (op_r == OP_LW) begin
                    mem_to_reg = 2'b01;
                end else begin
                    mem_to_reg = 2'b00;
                end
                retire_s     = 1'b1;
                next_state_s = ret_next_s;
            end
            default: begin
                // Codes 110/111 are unreachable. Recover to IDLE on the next edge.
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Status outputs taken directly from the state register.
    always_comb begin
        state = state_r;
        if (state_r != S_IDLE) begin
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
    end

`ifdef MC_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_r;

    // Retire counter. It adds 1 for each completed instruction and wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign retire_cnt = retire_cnt_r;
`else
    // Without the counter, CNT_W only feeds this width sanity guard.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end
`endif

endmodule
